// File: rtl/piso_shiftreg_pkg.sv
// Shared definitions for the parallel register / serial link family:
// transmitter state encoding and the default word width.
package piso_shiftreg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    localparam int PISO_WIDTH_DEFAULT = 8;

    function automatic int piso_count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bitcount.sv
// Bit position counter for the serial transmitter: runs 0..WIDTH-1 and
// flags the final bit of a word.
module piso_bitcount
    import piso_shiftreg_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEFAULT,
    localparam int CW   = piso_count_width(WIDTH)
) (
    input  logic clk,
    input  logic clear,
    input  logic start,
    input  logic enable,
    output logic last
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = '0;
        end else if (enable && !last) begin
            count_d = count_q + CW'(1);
        end
    end

    // Saturates at the last index so the count can never run past WIDTH-1.
    assign last = (count_q == LAST_IDX);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_shiftreg.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on load&ready
// and drives it onto sout one bit per clock with a frame strobe and done pulse.
module piso_shiftreg
    import piso_shiftreg_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic             ready,
    output logic             sout,
    output logic             sframe,
    output logic             done
);

    // Handshake: a word is taken on any rising edge where load and ready are
    // both high. ready depends only on registered state, never on load or D;
    // a load seen while ready is low is dropped, not queued.

    piso_state_e      state_q;
    piso_state_e      state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             accept;
    logic             cnt_start;
    logic             cnt_en;
    logic             cnt_last;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    piso_bitcount #(
        .WIDTH (WIDTH)
    ) u_bitcount (
        .clk    (clk),
        .clear  (clear),
        .start  (cnt_start),
        .enable (cnt_en),
        .last   (cnt_last)
    );

    always_comb begin
        ready     = (state_q == IDLE) || ((state_q == SHIFT) && cnt_last);
        accept    = load && ready;
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_start = 1'b0;
        cnt_en    = 1'b0;

        if (accept) begin
            state_d   = SHIFT;
            shreg_d   = D;
            cnt_start = 1'b1;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_last) begin
                        // Zeroing the register is what returns sout to 0 in IDLE.
                        state_d   = IDLE;
                        shreg_d   = '0;
                        cnt_start = 1'b1;
                    end else begin
                        shreg_d = shift_once(shreg_q);
                        cnt_en  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs are taken straight from flops: the output end of the shift
    // register and the state bit.
    assign sout   = out_bit(shreg_q);
    assign sframe = (state_q == SHIFT);
    assign done   = (state_q == SHIFT) && cnt_last;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: doc/piso_shiftreg.md
# piso_shiftreg

Parallel-in, serial-out transmitter that drains the 8-bit words produced by the sync load/clear register onto a single serial line, one bit per clock. It accepts a word through a ready/load handshake, shifts it out with a frame strobe, and pulses `done` on the last bit. It sits between the parallel register datapath and any serial consumer (the matching SIPO receiver).

## Interface
- `WIDTH`, 8: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

- `clk`  in  1  sole clock; all state changes on rising edge.
- `clear`  in  1  reset, asynchronous, active-high; clears all state immediately.
- `load`  in  1  request to accept `D`; only acts when `ready`=1.
- `D`  in  WIDTH  parallel word to transmit.
- `ready`  out  1  block can accept a word this cycle.
- `sout`  out  1  serial data bit, registered.
- `sframe`  out  1  high while `sout` carries a valid bit, registered.
- `done`  out  1  one-cycle pulse coincident with the last bit of a word.

## Operation
- States: IDLE, SHIFT.
- Reset values (clear=1): state=IDLE, shift register=0, bit count=0, `sout`=0, `sframe`=0, `done`=0, `ready`=1. `load` ignored while clear=1.
- `ready` = (state==IDLE) or (state==SHIFT and count==WIDTH-1). Decoded from registers only; no combinational path from `load` or `D`.
- Accept = `load` & `ready` at a rising edge. On accept: capture `D`, count←0, state←SHIFT; first bit (D[WIDTH-1] if MSB_FIRST else D[0]) appears on `sout` with `sframe`=1 after that same edge.
- SHIFT, count<WIDTH-1: shift by one toward the output end, count+1, `sframe` stays 1.
- SHIFT, count==WIDTH-1 (last bit on `sout`, `done`=1): next edge → accept if `load`=1 (next word's first bit follows with no gap, `sframe` stays 1, `done` drops), else state←IDLE, `sframe`←0, `sout`←0.
- `load` while `ready`=0: ignored, no effect on the current word, not queued.
- `D` only sampled on the accept edge; changes at other times have no effect.
- Count width: clog2(WIDTH); count never exceeds WIDTH-1.

## Timing
- Latency: accept edge → first bit valid, 0 extra cycles (visible right after accept edge).
- Word occupies exactly WIDTH consecutive cycles of `sframe`=1.
- `done` high for exactly one cycle per word, during bit WIDTH-1.
- Back-to-back throughput: one word per WIDTH cycles, no idle bubble.
- `clear` asserted mid-word: outputs go to reset values immediately (asynchronously); partial word is discarded, never resumed; `done` not pulsed.
- `clear` deasserted: `ready`=1; first accept possible at the next rising edge.

## Structure
- Shared package: state enum (IDLE, SHIFT), default WIDTH constant (8), shared with the register and the future SIPO receiver.
- One sub-module is natural: `piso_bitcount`, a 0..WIDTH-1 counter with clear/start/enable and a `last` flag driving `ready` and `done`.

## Test plan
- Reset: hold clear=1 for 3 cycles → `sout`=0, `sframe`=0, `done`=0, `ready`=1; `load`=1 with D=8'hFF during clear → nothing transmitted.
- Single word MSB-first: D=8'hA5, one-cycle load → `sout` = 1,0,1,0,0,1,0,1 over 8 cycles, `sframe`=1 for those 8, `done` only on the 8th, then IDLE with `sout`=0.
- LSB-first (MSB_FIRST=0): D=8'h01 → `sout` = 1,0,0,0,0,0,0,0.
- Back-to-back: load D=8'hFF, hold `load`=1 and set D=8'h00 during last bit → 16 contiguous `sframe` cycles (8 ones then 8 zeros), `done` pulses on cycles 8 and 16.
- Busy load ignored: load D=8'hF0, then `load`=1 with D=8'h0F on bit 3 → stream remains 1,1,1,1,0,0,0,0; no second word.
- Clear mid-word: load D=8'hC3, assert clear after 3 bits → outputs zero at once, no `done`; after release, load D=8'h81 → 1,0,0,0,0,0,0,1 transmitted intact.
